// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared types and helpers for the UART transmitter: the       |
// |               serializer state encoding, the idle line level and the       |
// |               data-bits code to bit-count mapping.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Serial line level while no frame is on the wire (mark state).
  localparam logic TX_IDLE_LVL = 1'b1;

  // 00=5, 01=6, 10=7, 11=8 data bits.
  function automatic logic [3:0] bits_from_code(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_fifo                                                 |
// | Description : DEPTH x 8 holding FIFO between the uDMA stream and the       |
// |               serializer. First-word-fall-through read port.               |
// | Ports       : clk_i/rstn_i  clock, async active-low reset (flushes)        |
// |               push_i/wdata_i write strobe and byte (ignored when full)     |
// |               pop_i/rdata_o  read strobe and head byte (ignored when empty)|
// |               full_o/empty_o/count_o occupancy status                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic [7:0]               wdata_i,
  input  logic                     pop_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_ptr_one = (AW+1)'(1);
  localparam logic [AW:0] c_depth   = (AW+1)'(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  logic        w_wr;
  logic        w_rd;

  assign w_wr = push_i && !full_o;
  assign w_rd = pop_i && !empty_o;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (w_wr) wptr_q <= wptr_q + c_ptr_one;
      if (w_rd) rptr_q <= rptr_q + c_ptr_one;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == c_depth);
  assign empty_o = (wptr_q == rptr_q);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_core                                                 |
// | Description : UART transmitter fed by the uDMA TX stream. A small FIFO     |
// |               absorbs bursts; the serializer sends start, 5-8 data bits    |
// |               LSB first, optional even parity and 1 or 2 stop bits.        |
// | Ports       : sys_clk_i/rstn_i       clock, async active-low reset         |
// |               cfg_en_i/cfg_div_i/cfg_bits_i/cfg_parity_en_i/cfg_stop_bits_i|
// |                                      line configuration, sampled per frame |
// |               data_tx_req_o/gnt_i/data_tx_i/valid_i/ready_o  uDMA stream   |
// |               tx_o                   serial line, idle high                |
// |               busy_o                 FIFO non-empty or frame in progress   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             sys_clk_i,
  input  logic             rstn_i,
  input  logic             cfg_en_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [1:0]       cfg_bits_i,
  input  logic             cfg_parity_en_i,
  input  logic             cfg_stop_bits_i,
  output logic             data_tx_req_o,
  input  logic             data_tx_gnt_i,
  input  logic [31:0]      data_tx_i,
  input  logic             data_tx_valid_i,
  output logic             data_tx_ready_o,
  output logic             tx_o,
  output logic             busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      c_full_cnt = (AW+1)'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] c_cnt_one  = DIV_W'(1);

  tx_state_e        state_q;
  logic             tx_q;
  logic             busy_q;
  logic             ready_q;
  logic             gnt_seen_q;
  logic [DIV_W-1:0] baud_cnt_q;
  logic [DIV_W-1:0] reload_q;
  logic [7:0]       shreg_q;
  logic [2:0]       bits_left_q;
  logic             parity_q;
  logic             parity_en_q;
  logic             stop_left_q;

  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_rdata;
  logic             w_full;
  logic             w_empty;
  logic [AW:0]      w_count;
  logic [AW:0]      w_count_d;
  logic             w_bit_end;
  logic [DIV_W-1:0] w_div_load;
  logic [3:0]       w_nbits;
  logic [7:0]       w_mask;
  logic             w_unused;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk_i),
    .rstn_i  (rstn_i),
    .push_i  (w_push),
    .wdata_i (data_tx_i[7:0]),
    .pop_i   (w_pop),
    .rdata_o (w_rdata),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // ready_q is derived from next-cycle occupancy, so it is never high on a full FIFO.
  assign w_push    = data_tx_valid_i && ready_q && !w_full;
  assign w_bit_end = (baud_cnt_q == '0);

  // Pop from IDLE, or at the very end of the last stop bit for a gapless next frame.
  assign w_pop = !w_empty && cfg_en_i &&
                 ((state_q == ST_IDLE) ||
                  ((state_q == ST_STOP) && w_bit_end && !stop_left_q));

  assign w_count_d  = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_div_load = (cfg_div_i == '0) ? '0 : (cfg_div_i - c_cnt_one);
  assign w_nbits    = bits_from_code(cfg_bits_i);
  assign w_mask     = 8'hFF >> (4'd8 - w_nbits);

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      tx_q        <= TX_IDLE_LVL;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      gnt_seen_q  <= 1'b0;
      baud_cnt_q  <= '0;
      reload_q    <= '0;
      shreg_q     <= '0;
      bits_left_q <= '0;
      parity_q    <= 1'b0;
      parity_en_q <= 1'b0;
      stop_left_q <= 1'b0;
    end else begin
      ready_q <= cfg_en_i && (w_count_d != c_full_cnt);
      busy_q  <= !w_empty || (state_q != ST_IDLE);
      if (data_tx_gnt_i) gnt_seen_q <= 1'b1;

      if ((state_q != ST_IDLE) && !w_bit_end) begin
        baud_cnt_q <= baud_cnt_q - c_cnt_one;
      end else begin
        baud_cnt_q <= reload_q;
        case (state_q)
          ST_IDLE: tx_q <= TX_IDLE_LVL;
          ST_START: begin
            state_q <= ST_DATA;
            tx_q    <= shreg_q[0];
            shreg_q <= {1'b0, shreg_q[7:1]};
          end
          ST_DATA: begin
            if (bits_left_q != 3'd0) begin
              tx_q        <= shreg_q[0];
              shreg_q     <= {1'b0, shreg_q[7:1]};
              bits_left_q <= bits_left_q - 3'd1;
            end else if (parity_en_q) begin
              state_q <= ST_PARITY;
              tx_q    <= parity_q;
            end else begin
              state_q <= ST_STOP;
              tx_q    <= TX_IDLE_LVL;
            end
          end
          ST_PARITY: begin
            state_q <= ST_STOP;
            tx_q    <= TX_IDLE_LVL;
          end
          ST_STOP: begin
            if (stop_left_q) begin
              stop_left_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= TX_IDLE_LVL;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            tx_q    <= TX_IDLE_LVL;
          end
        endcase
      end

      // Frame launch overrides the per-state updates above; config is snapshotted here.
      if (w_pop) begin
        state_q     <= ST_START;
        tx_q        <= 1'b0;
        baud_cnt_q  <= w_div_load;
        reload_q    <= w_div_load;
        shreg_q     <= w_rdata;
        bits_left_q <= 3'(w_nbits - 4'd1);
        parity_q    <= ^(w_rdata & w_mask);
        parity_en_q <= cfg_parity_en_i;
        stop_left_q <= cfg_stop_bits_i;
      end
    end
  end

  assign tx_o            = tx_q;
  assign busy_o          = busy_q;
  assign data_tx_ready_o = ready_q;
  assign data_tx_req_o   = ready_q;

  // Upper data lanes and the grant history are not needed by the serializer.
  assign w_unused = ^{data_tx_i[31:8], gnt_seen_q};

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_core                                              |
// | Description : Self-checking bench for uart_tx_core. Expected line levels   |
// |               come from a frame model built from the UART framing rules.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_core;

  logic        sys_clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        cfg_en_i = 1'b0;
  logic [15:0] cfg_div_i = 16'd4;
  logic [1:0]  cfg_bits_i = 2'b11;
  logic        cfg_parity_en_i = 1'b0;
  logic        cfg_stop_bits_i = 1'b0;
  logic        data_tx_req_o;
  logic        data_tx_gnt_i = 1'b0;
  logic [31:0] data_tx_i = '0;
  logic        data_tx_valid_i = 1'b0;
  logic        data_tx_ready_o;
  logic        tx_o;
  logic        busy_o;

  int tests = 0;
  int fails = 0;
  bit saw_not_ready;

  always #5 sys_clk = ~sys_clk;

  uart_tx_core #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
    .sys_clk_i       (sys_clk),
    .rstn_i          (rstn_i),
    .cfg_en_i        (cfg_en_i),
    .cfg_div_i       (cfg_div_i),
    .cfg_bits_i      (cfg_bits_i),
    .cfg_parity_en_i (cfg_parity_en_i),
    .cfg_stop_bits_i (cfg_stop_bits_i),
    .data_tx_req_o   (data_tx_req_o),
    .data_tx_gnt_i   (data_tx_gnt_i),
    .data_tx_i       (data_tx_i),
    .data_tx_valid_i (data_tx_valid_i),
    .data_tx_ready_o (data_tx_ready_o),
    .tx_o            (tx_o),
    .busy_o          (busy_o)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Level of frame bit number idx: start, data LSB first, optional even parity, stops.
  function automatic logic exp_bit(input logic [7:0] b, input int nbits, input bit par, input int idx);
    logic p;
    p = 1'b0;
    if (idx == 0) return 1'b0;
    if (idx <= nbits) return b[idx-1];
    if (par && idx == nbits + 1) begin
      for (int k = 0; k < nbits; k++) p ^= b[k];
      return p;
    end
    return 1'b1;
  endfunction

  // Call at a negedge. wait_start=0: the next negedge must already show the start bit.
  task automatic check_frame(input logic [7:0] b, input int nbits, input bit par, input bit stop2,
                             input int div, input bit wait_start, input string name);
    int per;
    int nb;
    bit found;
    logic e;
    per = (div == 0) ? 1 : div;
    nb  = 1 + nbits + (par ? 1 : 0) + 1 + (stop2 ? 1 : 0);
    if (wait_start) begin
      found = 1'b0;
      for (int k = 0; k < 600; k++) begin
        @(negedge sys_clk);
        if (tx_o === 1'b0) begin found = 1'b1; break; end
      end
      if (!found) begin
        tests++; fails++;
        $display("FAIL %s start: tx_o never fell (got %b, need 0)", name, tx_o);
        return;
      end
    end else begin
      @(negedge sys_clk);
    end
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < per; c++) begin
        if (i != 0 || c != 0) @(negedge sys_clk);
        e = exp_bit(b, nbits, par, i);
        tests++;
        if (tx_o !== e) begin
          fails++;
          $display("FAIL %s byte=%h bit%0d clk%0d: tx_o=%b expected %b", name, b, i, c, tx_o, e);
        end
      end
    end
  endtask

  // Call at a negedge; returns at the negedge after the beat was accepted.
  task automatic push_byte(input logic [7:0] b, input string name);
    bit ok;
    bit done;
    done = 1'b0;
    data_tx_i = {24'($urandom), b};
    data_tx_valid_i = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      ok = data_tx_ready_o;
      if (!ok) saw_not_ready = 1'b1;
      @(negedge sys_clk);
      if (ok) begin done = 1'b1; break; end
    end
    data_tx_valid_i = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s push: ready_o stayed %b, need 1", name, data_tx_ready_o);
    end
  endtask

  task automatic set_cfg(input logic [15:0] div, input logic [1:0] bits, input bit par, input bit stop2);
    cfg_div_i = div; cfg_bits_i = bits; cfg_parity_en_i = par; cfg_stop_bits_i = stop2;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    tests++; if (tx_o !== 1'b1) begin fails++; $display("FAIL reset_tx: tx_o=%b need 1", tx_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: busy_o=%b need 0", busy_o); end
    tests++; if (data_tx_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready: ready=%b need 0", data_tx_ready_o); end
    tests++; if (data_tx_req_o !== 1'b0) begin fails++; $display("FAIL reset_req: req=%b need 0", data_tx_req_o); end
    rstn_i = 1'b1;
    repeat (2) @(negedge sys_clk);
    tests++; if (data_tx_ready_o !== 1'b0) begin fails++; $display("FAIL disabled_ready: ready=%b need 0", data_tx_ready_o); end
    cfg_en_i = 1'b1;
    @(negedge sys_clk);
    tests++; if (data_tx_ready_o !== 1'b1) begin fails++; $display("FAIL enabled_ready: ready=%b need 1", data_tx_ready_o); end
    tests++; if (data_tx_req_o !== 1'b1) begin fails++; $display("FAIL enabled_req: req=%b need 1", data_tx_req_o); end
  endtask

  task automatic test_single_8n1();
    set_cfg(16'd4, 2'b11, 1'b0, 1'b0);
    @(negedge sys_clk);
    push_byte(8'hA5, "8n1");
    tests++; if (tx_o !== 1'b1) begin fails++; $display("FAIL 8n1_latency: tx_o=%b need 1 one cycle after push", tx_o); end
    check_frame(8'hA5, 8, 1'b0, 1'b0, 4, 1'b0, "8n1");
    repeat (3) @(negedge sys_clk);
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL 8n1_busy: busy_o=%b need 0", busy_o); end
    tests++; if (tx_o !== 1'b1) begin fails++; $display("FAIL 8n1_idle: tx_o=%b need 1", tx_o); end
  endtask

  task automatic test_7e2();
    set_cfg(16'd2, 2'b10, 1'b1, 1'b1);
    @(negedge sys_clk);
    push_byte(8'h03, "7e2");
    check_frame(8'h03, 7, 1'b1, 1'b1, 2, 1'b0, "7e2");
    @(negedge sys_clk);
    tests++; if (tx_o !== 1'b1) begin fails++; $display("FAIL 7e2_after: tx_o=%b need 1", tx_o); end
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    set_cfg(16'd2, 2'b11, 1'b0, 1'b0);
    saw_not_ready = 1'b0;
    @(negedge sys_clk);
    fork
      begin
        for (int i = 0; i < 6; i++) push_byte(q[i], "b2b");
      end
      begin
        for (int i = 0; i < 6; i++) check_frame(q[i], 8, 1'b0, 1'b0, 2, (i == 0), "b2b");
      end
    join
    tests++; if (saw_not_ready !== 1'b1) begin fails++; $display("FAIL b2b_full: ready_o never dropped (saw %b, need 1)", saw_not_ready); end
    repeat (3) @(negedge sys_clk);
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL b2b_busy: busy_o=%b need 0", busy_o); end
  endtask

  task automatic test_fast_div();
    for (int d = 0; d < 2; d++) begin
      set_cfg(16'(d), 2'b00, 1'b0, 1'b0);
      @(negedge sys_clk);
      push_byte(8'hFF, "div01");
      check_frame(8'hFF, 5, 1'b0, 1'b0, d, 1'b0, "div01");
      @(negedge sys_clk);
      tests++; if (tx_o !== 1'b1) begin fails++; $display("FAIL div%0d_after: tx_o=%b need 1", d, tx_o); end
      repeat (2) @(negedge sys_clk);
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0] b[3];
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    set_cfg(16'd4, 2'b11, 1'b0, 1'b0);
    @(negedge sys_clk);
    fork
      check_frame(b[0], 8, 1'b0, 1'b0, 4, 1'b1, "endrop");
      begin
        for (int i = 0; i < 3; i++) push_byte(b[i], "endrop");
        repeat (3) @(negedge sys_clk);
        cfg_en_i = 1'b0;
      end
    join
    tests++; if (data_tx_ready_o !== 1'b0) begin fails++; $display("FAIL endrop_ready: ready=%b need 0", data_tx_ready_o); end
    tests++; if (data_tx_req_o !== 1'b0) begin fails++; $display("FAIL endrop_req: req=%b need 0", data_tx_req_o); end
    for (int k = 0; k < 20; k++) begin
      @(negedge sys_clk);
      tests++; if (tx_o !== 1'b1) begin fails++; $display("FAIL endrop_hold: tx_o=%b need 1 (cycle %0d)", tx_o, k); end
    end
    tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL endrop_busy: busy_o=%b need 1", busy_o); end
    cfg_en_i = 1'b1;
    check_frame(b[1], 8, 1'b0, 1'b0, 4, 1'b1, "endrop_resume");
    check_frame(b[2], 8, 1'b0, 1'b0, 4, 1'b0, "endrop_resume");
    repeat (3) @(negedge sys_clk);
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL endrop_done: busy_o=%b need 0", busy_o); end
  endtask

  task automatic test_reset_midframe();
    set_cfg(16'd4, 2'b11, 1'b0, 1'b0);
    @(negedge sys_clk);
    push_byte(8'h55, "rst");
    push_byte(8'h99, "rst");
    repeat (10) @(negedge sys_clk);
    rstn_i = 1'b0;
    #1;
    tests++; if (tx_o !== 1'b1) begin fails++; $display("FAIL rst_tx: tx_o=%b need 1", tx_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rst_busy: busy_o=%b need 0", busy_o); end
    tests++; if (data_tx_ready_o !== 1'b0) begin fails++; $display("FAIL rst_ready: ready=%b need 0", data_tx_ready_o); end
    @(negedge sys_clk);
    rstn_i = 1'b1;
    repeat (4) @(negedge sys_clk);
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rst_flush: busy_o=%b need 0", busy_o); end
    tests++; if (tx_o !== 1'b1) begin fails++; $display("FAIL rst_idle: tx_o=%b need 1", tx_o); end
    push_byte(8'h0F, "rst_next");
    check_frame(8'h0F, 8, 1'b0, 1'b0, 4, 1'b0, "rst_next");
    repeat (3) @(negedge sys_clk);
  endtask

  // Random frames; config is scrambled mid-frame to confirm the snapshot holds.
  task automatic test_random();
    logic [7:0] b;
    logic [1:0] bits;
    bit par;
    bit stop2;
    int div;
    for (int it = 0; it < 10; it++) begin
      b = 8'($urandom);
      bits = 2'($urandom);
      par = 1'($urandom);
      stop2 = 1'($urandom);
      div = $urandom_range(0, 4);
      set_cfg(16'(div), bits, par, stop2);
      @(negedge sys_clk);
      push_byte(b, "rand");
      fork
        check_frame(b, 5 + int'(bits), par, stop2, div, 1'b0, "rand");
        begin
          repeat (2) @(negedge sys_clk);
          set_cfg(16'($urandom_range(0, 7)), 2'($urandom), 1'($urandom), 1'($urandom));
        end
      join
      repeat (2) @(negedge sys_clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_8n1();
    test_7e2();
    test_back_to_back();
    test_fast_div();
    test_enable_drop();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
